// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator: operands are folded into a carry-save
// (S, C) pair at full rate, then collapsed to binary by an iterative resolve phase.
module csa_stream_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] out_count
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] s_q, c_q, s_nxt, c_nxt;
  logic [ACC_WIDTH-1:0] d_ext, maj, sc;
  logic                 ovf_q, ovf_nxt;
  logic [CNT_WIDTH-1:0] count_q, count_nxt;
  logic                 accept;

  assign d_ext  = ACC_WIDTH'(in_data);
  // Majority of the three inputs is the carry word of one 3:2 compression.
  assign maj    = (s_q & c_q) | (s_q & d_ext) | (c_q & d_ext);
  assign sc     = s_q & c_q;

  assign in_ready = (state == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    s_nxt     = s_q;
    c_nxt     = c_q;
    ovf_nxt   = ovf_q;
    count_nxt = count_q;
    case (state)
      ACCUM: begin
        if (accept) begin
          s_nxt     = s_q ^ c_q ^ d_ext;
          c_nxt     = maj << 1;
          ovf_nxt   = ovf_q | maj[ACC_WIDTH-1];
          count_nxt = (count_q == '1) ? count_q : count_q + 1'b1;
          if (in_last) state_nxt = RESOLVE;
        end
      end
      RESOLVE: begin
        if (c_q == '0) begin
          state_nxt = OUTPUT;
        end else begin
          s_nxt   = s_q ^ c_q;
          c_nxt   = sc << 1;
          ovf_nxt = ovf_q | sc[ACC_WIDTH-1];
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          s_nxt     = '0;
          c_nxt     = '0;
          ovf_nxt   = 1'b0;
          count_nxt = '0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: every register, datapath included, is reset so no X ever reaches the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_nxt;
      s_q     <= s_nxt;
      c_q     <= c_nxt;
      ovf_q   <= ovf_nxt;
      count_q <= count_nxt;
    end
  end

  // Outputs are forced quiet while reset is asserted, whatever state is held.
  assign out_valid = (state == OUTPUT) && !rst;
  assign out_sum   = rst ? '0 : s_q;
  assign out_ovf   = rst ? 1'b0 : ovf_q;
  assign out_count = rst ? '0 : count_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Randomized self-checking bench for csa_stream_accumulator against an
// arithmetic packet-sum model (true sum, modulo result, overflow flag, saturating count).
module tb_csa_stream_accumulator;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 10;
  localparam int CNT_WIDTH = 8;
  localparam longint MODULUS = 64'd1 << ACC_WIDTH;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 in_last = 1'b0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovf;
  logic [CNT_WIDTH-1:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  longint model_sum = 0;
  int     model_n   = 0;

  csa_stream_accumulator #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last, input int gap);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    check("in_ready_accum", in_ready, 1);
    model_sum += longint'(d);
    model_n++;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for the result, checks it against the model, holds it for `hold`
  // cycles (optionally with junk input offered), then completes the handshake.
  task automatic get_result(input int exp_resolve, input int hold, input bit junk);
    int n = 0;
    logic [ACC_WIDTH-1:0] exp_sum;
    logic                 exp_ovf;
    logic [CNT_WIDTH-1:0] exp_cnt;
    exp_sum = ACC_WIDTH'(model_sum % MODULUS);
    exp_ovf = (model_sum >= MODULUS);
    exp_cnt = CNT_WIDTH'((model_n > CNT_MAX) ? CNT_MAX : model_n);
    while (!out_valid && n < 40) begin
      check("in_ready_resolve", in_ready, 0);
      n++;
      @(negedge clk);
    end
    check("out_valid_timeout", out_valid, 1);
    check("resolve_bound", (n >= 1 && n <= ACC_WIDTH + 1), 1);
    if (exp_resolve >= 0) check("resolve_cycles", n, exp_resolve);
    check("out_sum", out_sum, exp_sum);
    check("out_ovf", out_ovf, exp_ovf);
    check("out_count", out_count, exp_cnt);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'h11;
      in_last  = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", out_sum, exp_sum);
      check("hold_ovf", out_ovf, exp_ovf);
      check("hold_count", out_count, exp_cnt);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    model_sum = 0;
    model_n   = 0;
  endtask

  task automatic send_packet(input int len, input bit all_ff, input int max_gap);
    for (int i = 0; i < len; i++)
      send_beat(all_ff ? 8'hFF : WIDTH'($urandom_range(0, 255)), i == len - 1,
                $urandom_range(0, max_gap));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_count", out_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // 3 + 5 + 7
    send_beat(8'd3, 1'b0, 0);
    send_beat(8'd5, 1'b0, 0);
    send_beat(8'd7, 1'b1, 0);
    check("t1_sum_const", 32'(model_sum), 15);
    get_result(-1, 0, 1'b0);

    // Single operand: C stays zero, exactly one resolve cycle
    send_beat(8'hFF, 1'b1, 0);
    get_result(1, 0, 1'b0);

    // Four 0xFF fit, five overflow 10 bits
    send_packet(4, 1'b1, 0);
    get_result(-1, 0, 1'b0);
    send_packet(5, 1'b1, 0);
    get_result(-1, 0, 1'b0);

    // Backpressure with operands offered during OUTPUT, then a clean packet
    send_beat(8'd9, 1'b1, 0);
    get_result(-1, 5, 1'b1);
    send_beat(8'd2, 1'b1, 0);
    get_result(-1, 0, 1'b0);

    // Reset mid-packet discards partial state
    send_beat(8'h40, 1'b0, 0);
    send_beat(8'h40, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_sum", out_sum, 0);
    rst = 1'b0;
    model_sum = 0;
    model_n   = 0;
    @(negedge clk);
    send_beat(8'd9, 1'b1, 0);
    get_result(-1, 0, 1'b0);

    // Reset while a result is waiting
    send_beat(8'd77, 1'b1, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("outrst_valid", out_valid, 0);
    check("outrst_count", out_count, 0);
    rst = 1'b0;
    model_sum = 0;
    model_n   = 0;
    @(negedge clk);
    check("outrst_in_ready", in_ready, 1);

    // Random packets: short ones (often no overflow) and long ones (count saturates)
    for (int p = 0; p < 40; p++) begin
      int len;
      len = (p % 2 == 0) ? $urandom_range(1, 6) : $urandom_range(1, 300);
      if (p == 1) len = 300;
      send_packet(len, 1'b0, (p % 3 == 0) ? 2 : 0);
      get_result(-1, $urandom_range(0, 3), p % 4 == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
